// File: rtl/cdb_writeback_arbiter_pkg.sv
// Shared types for the CDB writeback stage.
//   wb_entry_t : one functional-unit result as it is buffered in a source FIFO
//   cdb_t      : one CDB lane as seen by the ROB, reservation stations and PRF
//   arb_mode_e : arbitration policy selector for the writeback arbiter
package cdb_writeback_arbiter_pkg;

  localparam int FUNC_UNIT_NUM = 4;
  localparam int N             = 2;
  localparam int PRF_BITS      = 6;
  localparam int ROB_BITS      = 5;
  localparam int XLEN          = 32;

  typedef enum logic {
    ARB_RR    = 1'b0,
    ARB_FIXED = 1'b1
  } arb_mode_e;

  typedef struct packed {
    logic [PRF_BITS-1:0] dest_prf;
    logic [ROB_BITS-1:0] rob_entry;
    logic [XLEN-1:0]     branch_address;
    logic [XLEN-1:0]     value;
    logic                value_valid;
  } wb_entry_t;

  typedef struct packed {
    logic                valid;
    logic [PRF_BITS-1:0] dest_prf;
    logic [ROB_BITS-1:0] rob_entry;
    logic [XLEN-1:0]     branch_address;
    logic [XLEN-1:0]     value;
    logic                value_valid;
  } cdb_t;

  // Promote a buffered result to a live CDB lane.
  function automatic cdb_t to_cdb(input wb_entry_t e);
    cdb_t c;
    c.valid          = 1'b1;
    c.dest_prf       = e.dest_prf;
    c.rob_entry      = e.rob_entry;
    c.branch_address = e.branch_address;
    c.value          = e.value;
    c.value_valid    = e.value_valid;
    return c;
  endfunction

endpackage

// File: rtl/cdb_writeback_arbiter_if.sv
// Bundle between the functional units and the writeback arbiter.
//   src_valid/src_pkt : FU results offered this cycle (master drives)
//   src_ready         : per-source FIFO has room (slave drives)
//   cdb_output        : NUM_CDB broadcast lanes (slave drives)
//   src_grant         : per-source head dequeued this cycle (slave drives)
//   occupancy         : per-source FIFO entry count (slave drives)
interface cdb_writeback_arbiter_if
  import cdb_writeback_arbiter_pkg::*;
#(
  parameter int NUM_SRC = FUNC_UNIT_NUM,
  parameter int NUM_CDB = N,
  parameter int DEPTH   = 2
);
  localparam int CW = $clog2(DEPTH + 1);

  logic      [NUM_SRC-1:0]         src_valid;
  wb_entry_t [NUM_SRC-1:0]         src_pkt;
  logic      [NUM_SRC-1:0]         src_ready;
  cdb_t      [NUM_CDB-1:0]         cdb_output;
  logic      [NUM_SRC-1:0]         src_grant;
  logic      [NUM_SRC-1:0][CW-1:0] occupancy;

  modport master (
    output src_valid, src_pkt,
    input  src_ready, cdb_output, src_grant, occupancy
  );

  modport slave (
    input  src_valid, src_pkt,
    output src_ready, cdb_output, src_grant, occupancy
  );
endinterface

// File: rtl/cdb_writeback_arbiter_wb_fifo.sv
// Per-source result FIFO.
//   clock, reset : system clock, synchronous active-high reset
//   flush        : synchronous squash of all entries
//   enq/enq_data : write a result at the tail (ignored when full or flushing)
//   deq          : pop the head (ignored when empty)
//   head         : current head entry (only meaningful while count != 0)
//   count        : number of valid entries
module wb_fifo
  import cdb_writeback_arbiter_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          flush,
  input  logic          enq,
  input  wb_entry_t     enq_data,
  input  logic          deq,
  output wb_entry_t     head,
  output logic [CW-1:0] count
);

  wb_entry_t     mem [DEPTH];
  logic [AW-1:0] head_ptr;
  logic [AW-1:0] tail_ptr;
  logic          do_enq;
  logic          do_deq;

  assign do_enq = enq && (count != CW'(DEPTH));
  assign do_deq = deq && (count != '0);
  assign head   = mem[head_ptr];

  // Explicit wrap keeps DEPTH == 1 pinned to slot 0.
  function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (do_enq) begin
        mem[tail_ptr] <= enq_data;
        tail_ptr      <= bump(tail_ptr);
      end
      if (do_deq) begin
        head_ptr <= bump(head_ptr);
      end
      case ({do_enq, do_deq})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cdb_writeback_arbiter.sv
// Writeback stage: buffers each FU result in its own FIFO and broadcasts up to
// NUM_CDB FIFO heads per cycle onto the CDB.
//   clock, reset : system clock, synchronous active-high reset
//   nuke         : squash every buffered result and restart arbitration
//   wb (slave)   : src_valid/src_pkt in; src_ready, cdb_output, src_grant,
//                  occupancy out
module cdb_writeback_arbiter
  import cdb_writeback_arbiter_pkg::*;
#(
  parameter int        NUM_SRC  = FUNC_UNIT_NUM,
  parameter int        NUM_CDB  = N,
  parameter int        DEPTH    = 2,
  parameter arb_mode_e ARB_MODE = ARB_RR
) (
  input logic                    clock,
  input logic                    reset,
  input logic                    nuke,
  cdb_writeback_arbiter_if.slave wb
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int LW = (NUM_CDB > 1) ? $clog2(NUM_CDB) : 1;

  wb_entry_t [NUM_SRC-1:0]         heads;
  logic      [NUM_SRC-1:0][CW-1:0] counts;
  logic      [NUM_SRC-1:0]         req;
  logic      [NUM_SRC-1:0]         ready;
  logic      [NUM_SRC-1:0]         grant;
  cdb_t      [NUM_CDB-1:0]         lanes;
  logic      [PW-1:0]              rr_ptr;
  logic      [PW-1:0]              rr_next;
  logic                            squash;

  assign squash = reset || nuke;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clock    (clock),
      .reset    (reset),
      .flush    (nuke),
      .enq      (wb.src_valid[i]),
      .enq_data (wb.src_pkt[i]),
      .deq      (grant[i]),
      .head     (heads[i]),
      .count    (counts[i])
    );
    assign req[i]   = (counts[i] != '0);
    // Ready depends only on the registered count, so a full FIFO never
    // relies on a same-cycle dequeue to accept a new result.
    assign ready[i] = (counts[i] != CW'(DEPTH));
  end

  // Scan sources starting at rr_ptr (or 0 in fixed mode); the first NUM_CDB
  // requesters take lanes in scan order. Nothing is granted while squashing.
  always_comb begin
    logic [PW-1:0] idx;
    int            used;
    grant   = '0;
    lanes   = '0;
    rr_next = rr_ptr;
    idx     = '0;
    used    = 0;
    for (int j = 0; j < NUM_SRC; j++) begin
      if (ARB_MODE == ARB_RR) begin
        idx = PW'((int'(rr_ptr) + j) % NUM_SRC);
      end else begin
        idx = PW'(j);
      end
      if (!squash && req[idx] && (used < NUM_CDB)) begin
        grant[idx]        = 1'b1;
        lanes[LW'(used)]  = to_cdb(heads[idx]);
        used              = used + 1;
        if (ARB_MODE == ARB_RR) begin
          rr_next = PW'((int'(idx) + 1) % NUM_SRC);
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (squash) begin
      rr_ptr <= '0;
    end else begin
      rr_ptr <= rr_next;
    end
  end

  assign wb.src_ready  = ready;
  assign wb.src_grant  = grant;
  assign wb.cdb_output = lanes;
  assign wb.occupancy  = counts;

endmodule

// File: tb/tb_cdb_writeback_arbiter.sv
// Directed bench for cdb_writeback_arbiter: a round-robin instance (4 sources,
// 2 lanes) driven from a vector table, and a fixed-priority instance
// (4 sources, 1 lane) driven by hand-written multi-cycle sequences.
module tb_cdb_writeback_arbiter;
  import cdb_writeback_arbiter_pkg::*;

  logic clock;
  logic rst_rr;
  logic rst_fx;
  logic nuke_rr;
  logic nuke_fx;

  int n_vec;
  int n_fail;

  cdb_writeback_arbiter_if #(.NUM_SRC(4), .NUM_CDB(2), .DEPTH(2)) rr_if ();
  cdb_writeback_arbiter_if #(.NUM_SRC(4), .NUM_CDB(1), .DEPTH(2)) fx_if ();

  cdb_writeback_arbiter #(.NUM_SRC(4), .NUM_CDB(2), .DEPTH(2), .ARB_MODE(ARB_RR)) dut_rr (
    .clock (clock),
    .reset (rst_rr),
    .nuke  (nuke_rr),
    .wb    (rr_if)
  );

  cdb_writeback_arbiter #(.NUM_SRC(4), .NUM_CDB(1), .DEPTH(2), .ARB_MODE(ARB_FIXED)) dut_fx (
    .clock (clock),
    .reset (rst_fx),
    .nuke  (nuke_fx),
    .wb    (fx_if)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [3:0] valid;
    int         rob [4];
    logic       nuke;
    logic [3:0] grant;
    logic [3:0] ready;
    int         occ [4];
    int         lane [2];
  } vec_t;

  vec_t vecs [$];

  // Each rob tag maps to a distinct, easily recognisable packet.
  function automatic wb_entry_t make_pkt(input int rob);
    wb_entry_t p;
    p.dest_prf       = PRF_BITS'(rob + 3);
    p.rob_entry      = ROB_BITS'(rob);
    p.branch_address = 32'h0000_1000 + 32'(rob * 4);
    p.value          = 32'hA500_0000 | 32'(rob);
    p.value_valid    = rob[0];
    return p;
  endfunction

  // Expected lane contents for a tag; a negative tag means an idle lane.
  function automatic cdb_t exp_lane(input int rob);
    cdb_t c;
    c = '0;
    if (rob >= 0) begin
      c.valid          = 1'b1;
      c.dest_prf       = PRF_BITS'(rob + 3);
      c.rob_entry      = ROB_BITS'(rob);
      c.branch_address = 32'h0000_1000 + 32'(rob * 4);
      c.value          = 32'hA500_0000 | 32'(rob);
      c.value_valid    = rob[0];
    end
    return c;
  endfunction

  task automatic check_bits(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic [3:0] valid, input int r0, input int r1, input int r2,
                         input int r3, input logic nuke, input logic [3:0] grant,
                         input logic [3:0] ready, input int o0, input int o1, input int o2,
                         input int o3, input int l0, input int l1);
    vec_t v;
    v.valid   = valid;
    v.rob     = '{r0, r1, r2, r3};
    v.nuke    = nuke;
    v.grant   = grant;
    v.ready   = ready;
    v.occ     = '{o0, o1, o2, o3};
    v.lane    = '{l0, l1};
    vecs.push_back(v);
  endtask

  task automatic apply_stimulus(input vec_t v);
    rr_if.src_valid = v.valid;
    nuke_rr         = v.nuke;
    for (int i = 0; i < 4; i++) rr_if.src_pkt[i] = make_pkt(v.rob[i]);
  endtask

  task automatic check_output(input int n, input vec_t v);
    check_bits($sformatf("rr v%0d grant", n), 128'(rr_if.src_grant), 128'(v.grant));
    check_bits($sformatf("rr v%0d ready", n), 128'(rr_if.src_ready), 128'(v.ready));
    for (int i = 0; i < 4; i++)
      check_bits($sformatf("rr v%0d occ%0d", n, i), 128'(rr_if.occupancy[i]), 128'(v.occ[i]));
    for (int k = 0; k < 2; k++)
      check_bits($sformatf("rr v%0d lane%0d", n, k), 128'(rr_if.cdb_output[k]), 128'(exp_lane(v.lane[k])));
  endtask

  // One fixed-priority cycle: only sources 0 and 3 are driven, src 3 standing
  // in for the lowest-priority FU.
  task automatic fx_step(input string name, input logic rst, input logic [3:0] valid,
                         input int rob0, input int rob3, input logic [3:0] grant,
                         input logic [3:0] ready, input int occ0, input int occ3, input int lane);
    rst_fx          = rst;
    fx_if.src_valid = valid;
    fx_if.src_pkt[0] = make_pkt(rob0);
    fx_if.src_pkt[3] = make_pkt(rob3);
    @(negedge clock);
    if (valid[3] && !fx_if.src_ready[3])
      $display("[TB] %s: src3 offered while not ready, result expected to drop", name);
    check_bits({name, " grant"}, 128'(fx_if.src_grant), 128'(grant));
    check_bits({name, " ready"}, 128'(fx_if.src_ready), 128'(ready));
    check_bits({name, " occ0"},  128'(fx_if.occupancy[0]), 128'(occ0));
    check_bits({name, " occ3"},  128'(fx_if.occupancy[3]), 128'(occ3));
    check_bits({name, " lane0"}, 128'(fx_if.cdb_output[0]), 128'(exp_lane(lane)));
    @(posedge clock);
    #1;
  endtask

  initial begin
    cdb_t want;
    n_vec  = 0;
    n_fail = 0;

    rst_rr = 1'b1;
    rst_fx = 1'b1;
    nuke_rr = 1'b0;
    nuke_fx = 1'b0;
    rr_if.src_valid = '0;
    fx_if.src_valid = '0;
    for (int i = 0; i < 4; i++) begin
      rr_if.src_pkt[i] = '0;
      fx_if.src_pkt[i] = '0;
    end

    // Reset held two cycles; lanes must stay idle while in reset.
    @(posedge clock);
    #1;
    @(negedge clock);
    check_bits("reset cdb lane0", 128'(rr_if.cdb_output[0]), 128'(0));
    check_bits("reset grant", 128'(rr_if.src_grant), 128'(0));
    @(posedge clock);
    #1;
    rst_rr = 1'b0;
    rst_fx = 1'b0;
    @(negedge clock);
    check_bits("post-reset rr ready", 128'(rr_if.src_ready), 128'(4'b1111));
    check_bits("post-reset rr cdb", 128'(rr_if.cdb_output), 128'(0));
    check_bits("post-reset rr occ", 128'(rr_if.occupancy), 128'(0));
    check_bits("post-reset fx ready", 128'(fx_if.src_ready), 128'(4'b1111));
    check_bits("post-reset fx cdb", 128'(fx_if.cdb_output), 128'(0));
    @(posedge clock);
    #1;

    //      valid    rob s0..s3        nuke  grant    ready    occ s0..s3   lanes
    add_vec(4'b1111,  1,  2,  3,  4, 1'b0, 4'b0000, 4'b1111, 0, 0, 0, 0, -1, -1);
    add_vec(4'b0000,  0,  0,  0,  0, 1'b0, 4'b0011, 4'b1111, 1, 1, 1, 1,  1,  2);
    add_vec(4'b0000,  0,  0,  0,  0, 1'b0, 4'b1100, 4'b1111, 0, 0, 1, 1,  3,  4);
    add_vec(4'b0000,  0,  0,  0,  0, 1'b0, 4'b0000, 4'b1111, 0, 0, 0, 0, -1, -1);
    add_vec(4'b0100,  0,  0,  5,  0, 1'b0, 4'b0000, 4'b1111, 0, 0, 0, 0, -1, -1);
    add_vec(4'b0000,  0,  0,  0,  0, 1'b0, 4'b0100, 4'b1111, 0, 0, 1, 0,  5, -1);
    add_vec(4'b1111,  6,  7,  8,  9, 1'b0, 4'b0000, 4'b1111, 0, 0, 0, 0, -1, -1);
    add_vec(4'b0000,  0,  0,  0,  0, 1'b0, 4'b1001, 4'b1111, 1, 1, 1, 1,  9,  6);
    add_vec(4'b0000,  0,  0,  0,  0, 1'b0, 4'b0110, 4'b1111, 0, 1, 1, 0,  7,  8);
    add_vec(4'b0000,  0,  0,  0,  0, 1'b0, 4'b0000, 4'b1111, 0, 0, 0, 0, -1, -1);
    add_vec(4'b0001, 10,  0,  0,  0, 1'b0, 4'b0000, 4'b1111, 0, 0, 0, 0, -1, -1);
    add_vec(4'b0001, 11,  0,  0,  0, 1'b0, 4'b0001, 4'b1111, 1, 0, 0, 0, 10, -1);
    add_vec(4'b0001, 12,  0,  0,  0, 1'b0, 4'b0001, 4'b1111, 1, 0, 0, 0, 11, -1);
    add_vec(4'b0000,  0,  0,  0,  0, 1'b0, 4'b0001, 4'b1111, 1, 0, 0, 0, 12, -1);
    add_vec(4'b1111, 13, 14, 15, 16, 1'b0, 4'b0000, 4'b1111, 0, 0, 0, 0, -1, -1);
    add_vec(4'b1111, 17, 18, 19, 20, 1'b0, 4'b0110, 4'b1111, 1, 1, 1, 1, 14, 15);
    add_vec(4'b0110,  0, 29, 30,  0, 1'b0, 4'b1001, 4'b0110, 2, 1, 1, 2, 16, 13);
    add_vec(4'b1111, 21, 22, 23, 24, 1'b1, 4'b0000, 4'b1001, 1, 2, 2, 1, -1, -1);
    add_vec(4'b0000,  0,  0,  0,  0, 1'b0, 4'b0000, 4'b1111, 0, 0, 0, 0, -1, -1);
    add_vec(4'b1111, 25, 26, 27, 28, 1'b0, 4'b0000, 4'b1111, 0, 0, 0, 0, -1, -1);
    add_vec(4'b0000,  0,  0,  0,  0, 1'b0, 4'b0011, 4'b1111, 1, 1, 1, 1, 25, 26);
    add_vec(4'b0000,  0,  0,  0,  0, 1'b0, 4'b1100, 4'b1111, 0, 0, 1, 1, 27, 28);

    foreach (vecs[n]) begin
      apply_stimulus(vecs[n]);
      @(negedge clock);
      check_output(n, vecs[n]);
      @(posedge clock);
      #1;
    end
    rr_if.src_valid = '0;
    nuke_rr         = 1'b0;

    // Field pass-through: an arbitrary packet on src1 reappears on lane 0.
    rr_if.src_valid                   = 4'b0010;
    rr_if.src_pkt[1].dest_prf         = 6'd7;
    rr_if.src_pkt[1].rob_entry        = 5'd9;
    rr_if.src_pkt[1].branch_address   = 32'h0000_0100;
    rr_if.src_pkt[1].value            = 32'hDEAD_BEEF;
    rr_if.src_pkt[1].value_valid      = 1'b1;
    @(posedge clock);
    #1;
    rr_if.src_valid = '0;
    want.valid          = 1'b1;
    want.dest_prf       = 6'd7;
    want.rob_entry      = 5'd9;
    want.branch_address = 32'h0000_0100;
    want.value          = 32'hDEAD_BEEF;
    want.value_valid    = 1'b1;
    @(negedge clock);
    check_bits("passthru lane0", 128'(rr_if.cdb_output[0]), 128'(want));
    check_bits("passthru lane1", 128'(rr_if.cdb_output[1]), 128'(0));
    check_bits("passthru grant", 128'(rr_if.src_grant), 128'(4'b0010));
    @(posedge clock);
    #1;

    // Fixed priority: src0 hogs the single lane while src3 fills and overflows,
    // then src3 drains in order once src0 is empty.
    fx_step("fx c0", 1'b0, 4'b1001, 1, 20, 4'b0000, 4'b1111, 0, 0, -1);
    fx_step("fx c1", 1'b0, 4'b1001, 2, 21, 4'b0001, 4'b1111, 1, 1,  1);
    fx_step("fx c2", 1'b0, 4'b1001, 3, 22, 4'b0001, 4'b0111, 1, 2,  2);
    fx_step("fx c3", 1'b0, 4'b0000, 0,  0, 4'b0001, 4'b0111, 1, 2,  3);
    fx_step("fx c4", 1'b0, 4'b0000, 0,  0, 4'b1000, 4'b0111, 0, 2, 20);
    fx_step("fx c5", 1'b0, 4'b0000, 0,  0, 4'b1000, 4'b1111, 0, 1, 21);
    fx_step("fx c6", 1'b0, 4'b0000, 0,  0, 4'b0000, 4'b1111, 0, 0, -1);
    // Reset mid-run: a buffered entry must not broadcast during the reset cycle.
    fx_step("fx c7", 1'b0, 4'b0001, 5,  0, 4'b0000, 4'b1111, 0, 0, -1);
    fx_step("fx c8", 1'b1, 4'b0000, 0,  0, 4'b0000, 4'b1111, 1, 0, -1);
    fx_step("fx c9", 1'b0, 4'b0000, 0,  0, 4'b0000, 4'b1111, 0, 0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
